chipmunk_memsys: RTL and testbench
==================================

# chipmunk_memsys

Memory-side responder for the Chipmunk CPU bus. It provides the byte RAM the CPU fetches from and writes to, a host loader that fills RAM while the CPU is held in reset, and a memory-mapped output FIFO drained by the host. It sits between the CPU core and the board/testbench host and owns CPU reset sequencing.

## Interface

Parameters:
- ADDR_W, 12, CPU address width; RAM holds 2^ADDR_W bytes.
- OUT_ADDR, 12'hFF0, write: push byte into output FIFO; read: FIFO status.
- FIFO_DEPTH, 4, output FIFO depth (power of two).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state below (RAM contents not cleared).
- addr  in  ADDR_W  CPU address.
- wdata  in  8  CPU write data.
- we  in  1  high for the whole CPU write cycle; the write commits at the rising edge ending that cycle.
- rdata  out  8  CPU read data, combinational from addr.
- cpu_done  in  1  CPU halt indication.
- cpu_rst_n  out  1  active-low reset to the CPU; registered.
- load_start  in  1  one-cycle pulse, begins a load at address 0.
- load_valid / load_ready / load_data[7:0] / load_last  in/out/in/in  byte-stream loader handshake.
- out_valid / out_ready / out_data[7:0]  out/in/out  output FIFO drain handshake.
- out_overflow  out  1  sticky: CPU pushed while FIFO was full.
- halted  out  1  one-cycle pulse when a run ends on cpu_done.

## Operation

- States: IDLE, LOAD, RELEASE, RUN. Reset -> IDLE.
- IDLE: cpu_rst_n=0, load_ready=0. load_start -> LOAD and load pointer := 0.
- LOAD: load_ready=1. Each cycle with load_valid&load_ready writes load_data to RAM[ptr], ptr := ptr+1 mod 2^ADDR_W (silent wrap). Transfer with load_last=1 -> RELEASE. load_start in LOAD restarts pointer at 0.
- RELEASE: one cycle, cpu_rst_n still 0 -> RUN.
- RUN: cpu_rst_n=1. cpu_done=1 -> IDLE, halted pulses for that one cycle, cpu_rst_n returns to 0 at the same edge. load_start ignored in RUN and RELEASE.
- CPU accesses honoured only in RUN; we outside RUN is ignored.
- addr != OUT_ADDR: read returns RAM[addr]; write stores wdata into RAM[addr].
- addr == OUT_ADDR: write pushes wdata into FIFO (RAM untouched); read returns {4'b0, out_overflow, count[2:0]}, count 0..FIFO_DEPTH.
- FIFO: out_valid = (count != 0); out_data = head, 0 when empty. Pop on out_valid&out_ready.
- Push when full: byte dropped, out_overflow := 1. Push and pop in the same cycle while full: pop frees a slot first, push accepted, count unchanged, no overflow.
- Push and pop same cycle at count 1..3: count unchanged, order preserved.
- out_overflow cleared only by reset; FIFO contents and count survive RUN->IDLE.

## Timing

- Reset values: cpu_rst_n=0, load_ready=0, out_valid=0, out_data=0, out_overflow=0, halted=0, count=0, state IDLE.
- rdata: zero-cycle latency from addr; a RAM byte written at edge N is visible on rdata after edge N.
- Loader: 1 byte/cycle max; load_ready is a function of state only (no dependence on load_valid).
- CPU first runs 2 edges after the load_last transfer (LOAD->RELEASE->RUN).
- FIFO: push at edge N -> out_valid high after edge N.
- Reset mid-LOAD or mid-RUN: immediate return to IDLE, cpu_rst_n low asynchronously; bytes already written stay in RAM.

## Test plan

- Load 3 bytes A9,05,83 with load_last on third -> RAM[0..2] hold them; cpu_rst_n rises exactly 2 edges after the third transfer.
- RUN, write 8'h42 to 12'h010 then read 12'h010 -> rdata=8'h42; write 8'h55 to OUT_ADDR -> out_valid=1, out_data=8'h55, RAM[OUT_ADDR] unchanged.
- out_ready=0, push 5 bytes 1..5 -> status reads 8'h04 then 8'h0C after 5th; drain yields 1,2,3,4.
- Full FIFO, push 8'h99 with out_ready=1 same cycle -> pop of 1, 8'h99 accepted, overflow stays 0, count stays 4.
- RUN, assert cpu_done -> halted one-cycle pulse, cpu_rst_n=0, state IDLE; we in IDLE to 12'h010 leaves RAM unchanged.
- Assert reset mid-LOAD after 2 bytes -> load_ready=0 immediately; new load_start restarts at address 0.

Source files
------------

// File: rtl/chipmunk_memsys.sv
// Memory-side responder for the Chipmunk CPU: byte RAM, host loader, CPU reset
// sequencing and a memory-mapped output FIFO drained by the host.
module chipmunk_memsys #(
    parameter int                ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] OUT_ADDR   = 12'hFF0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    input  logic              we,
    output logic [7:0]        rdata,
    input  logic              cpu_done,
    output logic              cpu_rst_n,
    input  logic              load_start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_overflow,
    output logic              halted
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;

    state_t            state, nextState;
    logic [7:0]        mem [2**ADDR_W];
    logic [ADDR_W-1:0] loadPtr;
    logic [7:0]        fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rdPtr, wrPtr;
    logic [CNT_W-1:0]  count;
    logic [2:0]        countStatus;
    logic              cpuRun, outSel, loadFire, ramWr, push, pop, full, pushOk;

    assign cpuRun   = (state == RUN);
    assign outSel   = (addr == OUT_ADDR);
    assign loadFire = load_valid && load_ready;
    assign ramWr    = cpuRun && we && !outSel;
    assign push     = cpuRun && we && outSel;
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign pop      = out_valid && out_ready;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign pushOk   = push && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cpu_rst_n <= 1'b0;
        end else begin
            state     <= nextState;
            cpu_rst_n <= (nextState == RUN);
        end
    end

    always_comb begin
        nextState  = state;
        load_ready = 1'b0;
        halted     = 1'b0;
        case (state)
            IDLE:    if (load_start) nextState = LOAD;
            LOAD: begin
                load_ready = 1'b1;
                if (loadFire && load_last) nextState = RELEASE;
            end
            RELEASE: nextState = RUN;
            RUN: begin
                if (cpu_done) begin
                    nextState = IDLE;
                    halted    = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loadPtr <= '0;
        end else if (load_start && (state == IDLE || state == LOAD)) begin
            loadPtr <= '0;
        end else if (loadFire) begin
            loadPtr <= loadPtr + ADDR_W'(1);
        end
    end

    // Loader and CPU never write in the same cycle: they own disjoint states.
    always_ff @(posedge clk) begin
        if (loadFire) begin
            mem[loadPtr] <= load_data;
        end else if (ramWr) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) fifoMem[wrPtr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            count        <= '0;
            out_overflow <= 1'b0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)    rdPtr <= rdPtr + PTR_W'(1);
            if (pushOk && !pop)      count <= count + CNT_W'(1);
            else if (!pushOk && pop) count <= count - CNT_W'(1);
            if (push && full && !pop) out_overflow <= 1'b1;
        end
    end

    assign out_valid   = (count != '0);
    assign out_data    = out_valid ? fifoMem[rdPtr] : 8'h00;
    assign countStatus = 3'(count);
    assign rdata       = outSel ? {4'b0000, out_overflow, countStatus} : mem[addr];

endmodule

// File: tb/tb_chipmunk_memsys.sv
// Directed, table-driven bench for chipmunk_memsys: one table row per clock cycle,
// inputs driven after the falling edge and outputs compared before the next rise.
module tb_chipmunk_memsys;

    localparam logic [11:0] O   = 12'hFF0;
    localparam logic [11:0] H10 = 12'h010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] addr = O;
    logic [7:0]  wdata = '0;
    logic        we = 1'b0;
    logic [7:0]  rdata;
    logic        cpu_done = 1'b0;
    logic        cpu_rst_n;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [7:0]  load_data = '0;
    logic        load_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_overflow;
    logic        halted;

    chipmunk_memsys #(.ADDR_W(12), .OUT_ADDR(12'hFF0), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
        .cpu_done(cpu_done), .cpu_rst_n(cpu_rst_n), .load_start(load_start),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .load_last(load_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_overflow(out_overflow), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ls, lv;
        logic [7:0]  ld;
        logic        ll, we;
        logic [11:0] a;
        logic [7:0]  wd;
        logic        rdy, done, cr;
        logic [7:0]  er;
        logic        eov;
        logic [7:0]  eod;
        logic        ecrn, elr, eh;
    } vec_t;

    vec_t tbl[$];
    int   nVec = 0;
    int   nMis = 0;
    int   split;

    task automatic add(input logic ls, input logic lv, input logic [7:0] ld, input logic ll,
                       input logic w, input logic [11:0] a, input logic [7:0] wd,
                       input logic rdy, input logic done, input logic cr, input logic [7:0] er,
                       input logic eov, input logic [7:0] eod,
                       input logic ecrn, input logic elr, input logic eh);
        vec_t v;
        v.ls = ls; v.lv = lv; v.ld = ld; v.ll = ll; v.we = w; v.a = a; v.wd = wd;
        v.rdy = rdy; v.done = done; v.cr = cr; v.er = er; v.eov = eov; v.eod = eod;
        v.ecrn = ecrn; v.elr = elr; v.eh = eh;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            $display("FAIL %s vec %0d: got %h, expected %h", nm, idx, act, exp);
            nMis++;
        end
    endtask

    task automatic apply(input int idx);
        vec_t v;
        v = tbl[idx];
        @(negedge clk);
        load_start = v.ls; load_valid = v.lv; load_data = v.ld; load_last = v.ll;
        we = v.we; addr = v.a; wdata = v.wd; out_ready = v.rdy; cpu_done = v.done;
        #1;
        nVec++;
        if (v.cr) chk("rdata", idx, rdata, v.er);
        chk("out_valid",  idx, {7'b0, out_valid},  {7'b0, v.eov});
        chk("out_data",   idx, out_data,           v.eod);
        chk("cpu_rst_n",  idx, {7'b0, cpu_rst_n},  {7'b0, v.ecrn});
        chk("load_ready", idx, {7'b0, load_ready}, {7'b0, v.elr});
        chk("halted",     idx, {7'b0, halted},     {7'b0, v.eh});
    endtask

    initial begin
        // Load A9,05,83; release; CPU RAM write/read; FIFO push, full, overflow, drain; halt.
        add(1,0,8'h00,0, 0,O,8'h00,     0,0, 1,8'h00, 0,8'h00, 0,0,0);
        add(0,1,8'hA9,0, 0,O,8'h00,     0,0, 1,8'h00, 0,8'h00, 0,1,0);
        add(0,0,8'h00,0, 0,12'h000,8'h00, 0,0, 1,8'hA9, 0,8'h00, 0,1,0);
        add(0,1,8'h05,0, 0,O,8'h00,     0,0, 1,8'h00, 0,8'h00, 0,1,0);
        add(0,1,8'h83,1, 0,O,8'h00,     0,0, 1,8'h00, 0,8'h00, 0,1,0);
        add(0,0,8'h00,0, 0,12'h000,8'h00, 0,0, 1,8'hA9, 0,8'h00, 0,0,0);
        add(0,0,8'h00,0, 0,12'h001,8'h00, 0,0, 1,8'h05, 0,8'h00, 1,0,0);
        add(0,0,8'h00,0, 0,12'h002,8'h00, 0,0, 1,8'h83, 0,8'h00, 1,0,0);
        add(0,0,8'h00,0, 1,H10,8'h42,   0,0, 0,8'h00, 0,8'h00, 1,0,0);
        add(0,0,8'h00,0, 0,H10,8'h00,   0,0, 1,8'h42, 0,8'h00, 1,0,0);
        add(0,0,8'h00,0, 1,O,8'h55,     0,0, 1,8'h00, 0,8'h00, 1,0,0);
        add(0,0,8'h00,0, 0,O,8'h00,     0,0, 1,8'h01, 1,8'h55, 1,0,0);
        add(0,0,8'h00,0, 0,O,8'h00,     1,0, 1,8'h01, 1,8'h55, 1,0,0);
        add(0,0,8'h00,0, 1,O,8'h01,     0,0, 1,8'h00, 0,8'h00, 1,0,0);
        add(0,0,8'h00,0, 1,O,8'h02,     0,0, 1,8'h01, 1,8'h01, 1,0,0);
        add(0,0,8'h00,0, 1,O,8'h03,     0,0, 1,8'h02, 1,8'h01, 1,0,0);
        add(0,0,8'h00,0, 1,O,8'h04,     0,0, 1,8'h03, 1,8'h01, 1,0,0);
        add(0,0,8'h00,0, 1,O,8'h99,     1,0, 1,8'h04, 1,8'h01, 1,0,0);
        add(0,0,8'h00,0, 0,O,8'h00,     0,0, 1,8'h04, 1,8'h02, 1,0,0);
        add(0,0,8'h00,0, 1,O,8'h05,     0,0, 1,8'h04, 1,8'h02, 1,0,0);
        add(0,0,8'h00,0, 0,O,8'h00,     0,0, 1,8'h0C, 1,8'h02, 1,0,0);
        add(0,0,8'h00,0, 0,O,8'h00,     1,0, 1,8'h0C, 1,8'h02, 1,0,0);
        add(0,0,8'h00,0, 0,O,8'h00,     1,0, 1,8'h0B, 1,8'h03, 1,0,0);
        add(0,0,8'h00,0, 0,O,8'h00,     1,0, 1,8'h0A, 1,8'h04, 1,0,0);
        add(0,0,8'h00,0, 0,O,8'h00,     1,0, 1,8'h09, 1,8'h99, 1,0,0);
        add(0,0,8'h00,0, 0,O,8'h00,     0,0, 1,8'h08, 0,8'h00, 1,0,0);
        add(0,0,8'h00,0, 0,O,8'h00,     0,1, 1,8'h08, 0,8'h00, 1,0,1);
        add(0,0,8'h00,0, 1,H10,8'h77,   0,0, 1,8'h42, 0,8'h00, 0,0,0);
        add(0,0,8'h00,0, 1,O,8'h11,     0,0, 1,8'h08, 0,8'h00, 0,0,0);
        add(0,0,8'h00,0, 0,H10,8'h00,   0,1, 1,8'h42, 0,8'h00, 0,0,0);
        add(1,0,8'h00,0, 0,O,8'h00,     0,0, 1,8'h08, 0,8'h00, 0,0,0);
        add(0,1,8'h11,0, 0,O,8'h00,     0,0, 1,8'h08, 0,8'h00, 0,1,0);
        add(0,1,8'h22,0, 0,O,8'h00,     0,0, 1,8'h08, 0,8'h00, 0,1,0);
        split = tbl.size();
        // After a mid-load reset: reload from address 0, earlier bytes kept.
        add(1,0,8'h00,0, 0,O,8'h00,     0,0, 1,8'h00, 0,8'h00, 0,0,0);
        add(0,1,8'h33,1, 0,O,8'h00,     0,0, 1,8'h00, 0,8'h00, 0,1,0);
        add(0,0,8'h00,0, 0,12'h000,8'h00, 0,0, 1,8'h33, 0,8'h00, 0,0,0);
        add(0,0,8'h00,0, 0,12'h001,8'h00, 0,0, 1,8'h22, 0,8'h00, 1,0,0);
        add(0,0,8'h00,0, 0,12'h002,8'h00, 0,0, 1,8'h83, 0,8'h00, 1,0,0);

        @(negedge clk);
        #1;
        nVec++;
        chk("rst cpu_rst_n",  -1, {7'b0, cpu_rst_n},  8'h00);
        chk("rst load_ready", -1, {7'b0, load_ready}, 8'h00);
        chk("rst out_valid",  -1, {7'b0, out_valid},  8'h00);
        chk("rst out_data",   -1, out_data,           8'h00);
        chk("rst halted",     -1, {7'b0, halted},     8'h00);
        chk("rst status",     -1, rdata,              8'h00);
        reset = 1'b0;

        for (int i = 0; i < split; i++) apply(i);

        @(negedge clk);
        load_start = 0; load_valid = 0; load_last = 0; we = 0; out_ready = 0;
        cpu_done = 0; addr = O;
        reset = 1'b1;
        #1;
        nVec++;
        chk("midload load_ready", -2, {7'b0, load_ready}, 8'h00);
        chk("midload cpu_rst_n",  -2, {7'b0, cpu_rst_n},  8'h00);
        chk("midload status",     -2, rdata,              8'h00);
        chk("midload out_valid",  -2, {7'b0, out_valid},  8'h00);
        #1;
        reset = 1'b0;

        for (int i = split; i < tbl.size(); i++) apply(i);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
